// File: rtl/ray_issue_scheduler.sv
// Raster-order pixel coordinate sequencer with credit-based flow control.
// Light position is snapshotted once per frame so a frame shades consistently.
module ray_issue_scheduler #(
    parameter int SCREEN_WIDTH  = 640,
    parameter int SCREEN_HEIGHT = 480,
    parameter int CREDITS       = 16,
    localparam int IW           = $clog2(CREDITS + 1)
) (
    input  logic          out_stream_aclk,
    input  logic          periph_resetn,
    input  logic          enable,
    input  logic [31:0]   light_x_in,
    input  logic [31:0]   light_y_in,
    input  logic [31:0]   light_z_in,
    output logic [31:0]   light_x,
    output logic [31:0]   light_y,
    output logic [31:0]   light_z,
    output logic [9:0]    coord_x,
    output logic [8:0]    coord_y,
    output logic          coords_valid,
    input  logic          coords_ready,
    output logic          coords_sof,
    output logic          coords_eol,
    input  logic          credit_return,
    output logic [IW-1:0] inflight,
    output logic          busy,
    output logic          frame_done,
    output logic          credit_err
);

    typedef enum logic [1:0] {IDLE, LATCH, ISSUE, DRAIN} state_e;

    localparam logic [9:0]    X_LAST = 10'(SCREEN_WIDTH - 1);
    localparam logic [8:0]    Y_LAST = 9'(SCREEN_HEIGHT - 1);
    localparam logic [IW-1:0] CRED_MAX = IW'(CREDITS);

    state_e        state_q, state_d;
    logic [9:0]    coord_x_q, coord_x_d;
    logic [8:0]    coord_y_q, coord_y_d;
    logic [IW-1:0] inflight_q, inflight_d;
    logic          credit_err_q, credit_err_d;
    logic [31:0]   light_x_q, light_x_d;
    logic [31:0]   light_y_q, light_y_d;
    logic [31:0]   light_z_q, light_z_d;

    logic handshake;
    logic last_x;
    logic last_pixel;

    assign handshake  = coords_valid && coords_ready;
    assign last_x     = (coord_x_q == X_LAST);
    assign last_pixel = last_x && (coord_y_q == Y_LAST);

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable) state_d = LATCH;
            LATCH:   state_d = ISSUE;
            ISSUE:   if (handshake && last_pixel) state_d = DRAIN;
            DRAIN:   if (inflight_q == '0) state_d = enable ? LATCH : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        coords_valid = (state_q == ISSUE) && (inflight_q < CRED_MAX);
        frame_done   = (state_q == DRAIN) && (inflight_q == '0);
        busy         = (state_q != IDLE);
        coords_sof   = coords_valid && (coord_x_q == '0) && (coord_y_q == '0);
        coords_eol   = coords_valid && last_x;
    end

    always_comb begin
        coord_x_d = coord_x_q;
        coord_y_d = coord_y_q;
        light_x_d = light_x_q;
        light_y_d = light_y_q;
        light_z_d = light_z_q;
        if (state_q == LATCH) begin
            coord_x_d = '0;
            coord_y_d = '0;
            light_x_d = light_x_in;
            light_y_d = light_y_in;
            light_z_d = light_z_in;
        end else if (handshake) begin
            if (last_pixel) begin
                coord_x_d = '0;
                coord_y_d = '0;
            end else if (last_x) begin
                coord_x_d = '0;
                coord_y_d = coord_y_q + 9'd1;
            end else begin
                coord_x_d = coord_x_q + 10'd1;
            end
        end
    end

    // A credit arriving with nothing in flight is bogus: flag it and ignore it.
    always_comb begin
        inflight_d   = inflight_q;
        credit_err_d = credit_err_q;
        if (credit_return && (inflight_q == '0)) begin
            credit_err_d = 1'b1;
            if (handshake) inflight_d = IW'(1);
        end else if (handshake && !credit_return) begin
            inflight_d = inflight_q + IW'(1);
        end else if (!handshake && credit_return) begin
            inflight_d = inflight_q - IW'(1);
        end
    end

    always_ff @(posedge out_stream_aclk or negedge periph_resetn) begin
        if (!periph_resetn) begin
            coord_x_q    <= '0;
            coord_y_q    <= '0;
            inflight_q   <= '0;
            credit_err_q <= 1'b0;
            light_x_q    <= '0;
            light_y_q    <= '0;
            light_z_q    <= '0;
        end else begin
            coord_x_q    <= coord_x_d;
            coord_y_q    <= coord_y_d;
            inflight_q   <= inflight_d;
            credit_err_q <= credit_err_d;
            light_x_q    <= light_x_d;
            light_y_q    <= light_y_d;
            light_z_q    <= light_z_d;
        end
    end

    assign coord_x    = coord_x_q;
    assign coord_y    = coord_y_q;
    assign inflight   = inflight_q;
    assign credit_err = credit_err_q;
    assign light_x    = light_x_q;
    assign light_y    = light_y_q;
    assign light_z    = light_z_q;

endmodule

// File: tb/tb_ray_issue_scheduler.sv
// Directed bench for ray_issue_scheduler on a 4x3 screen with 2 credits.
// Inputs change just after the falling edge; outputs are sampled 1 time unit later.
module tb_ray_issue_scheduler;

    localparam int SW = 4;
    localparam int SH = 3;
    localparam int CR = 2;
    localparam int IW = $clog2(CR + 1);

    logic          out_stream_aclk;
    logic          periph_resetn;
    logic          enable;
    logic [31:0]   light_x_in, light_y_in, light_z_in;
    logic [31:0]   light_x, light_y, light_z;
    logic [9:0]    coord_x;
    logic [8:0]    coord_y;
    logic          coords_valid;
    logic          coords_ready;
    logic          coords_sof;
    logic          coords_eol;
    logic          credit_return;
    logic [IW-1:0] inflight;
    logic          busy;
    logic          frame_done;
    logic          credit_err;

    int vectorCount = 0;
    int missCount   = 0;
    logic lastHs = 1'b0;

    ray_issue_scheduler #(
        .SCREEN_WIDTH (SW),
        .SCREEN_HEIGHT(SH),
        .CREDITS      (CR)
    ) dut (
        .out_stream_aclk(out_stream_aclk),
        .periph_resetn  (periph_resetn),
        .enable         (enable),
        .light_x_in     (light_x_in),
        .light_y_in     (light_y_in),
        .light_z_in     (light_z_in),
        .light_x        (light_x),
        .light_y        (light_y),
        .light_z        (light_z),
        .coord_x        (coord_x),
        .coord_y        (coord_y),
        .coords_valid   (coords_valid),
        .coords_ready   (coords_ready),
        .coords_sof     (coords_sof),
        .coords_eol     (coords_eol),
        .credit_return  (credit_return),
        .inflight       (inflight),
        .busy           (busy),
        .frame_done     (frame_done),
        .credit_err     (credit_err)
    );

    initial begin
        out_stream_aclk = 1'b0;
        forever #5 out_stream_aclk = ~out_stream_aclk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectorCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Credits, when enabled, are returned exactly one cycle after each issue.
    task automatic applyStimulus(input logic en, input logic rdy, input logic autoCredit);
        enable        = en;
        coords_ready  = rdy;
        credit_return = autoCredit && lastHs;
        #1;
    endtask

    task automatic tickCycle();
        lastHs = coords_valid && coords_ready;
        @(negedge out_stream_aclk);
    endtask

    task automatic resetDut();
        periph_resetn = 1'b0;
        enable        = 1'b0;
        coords_ready  = 1'b0;
        credit_return = 1'b0;
        lastHs        = 1'b0;
        @(negedge out_stream_aclk);
        @(negedge out_stream_aclk);
        periph_resetn = 1'b1;
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_valid", 32'(coords_valid), 32'd0);
        checkOutput("rst_inflight", 32'(inflight), 32'd0);
    endtask

    initial begin
        int hsCount, doneCount, cyc, firstCyc, lastIssueCyc, doneCyc, reissueCyc;
        periph_resetn = 1'b0;
        enable        = 1'b0;
        coords_ready  = 1'b0;
        credit_return = 1'b0;
        light_x_in    = 32'h0;
        light_y_in    = 32'h0000_1111;
        light_z_in    = 32'h0000_2222;
        @(negedge out_stream_aclk);

        // Basic frame, start latency, throughput and restart gap
        resetDut();
        checkOutput("rst_coord_x", 32'(coord_x), 32'd0);
        checkOutput("rst_frame_done", 32'(frame_done), 32'd0);
        checkOutput("rst_credit_err", 32'(credit_err), 32'd0);
        hsCount = 0; doneCount = 0; cyc = 0;
        firstCyc = -1; lastIssueCyc = -1; doneCyc = -1; reissueCyc = -1;
        while (hsCount < 13 && cyc < 100) begin
            applyStimulus(1'b1, 1'b1, 1'b1);
            if (frame_done) begin
                doneCount++;
                doneCyc = cyc;
            end
            if (coords_valid) begin
                if (hsCount == 0) firstCyc = cyc;
                if (hsCount < 12) begin
                    checkOutput("basic_x", 32'(coord_x), 32'(hsCount % SW));
                    checkOutput("basic_y", 32'(coord_y), 32'(hsCount / SW));
                    checkOutput("basic_sof", 32'(coords_sof), 32'(hsCount == 0));
                    checkOutput("basic_eol", 32'(coords_eol), 32'(hsCount % SW == SW - 1));
                    lastIssueCyc = cyc;
                end else begin
                    reissueCyc = cyc;
                    checkOutput("reissue_xy", {coord_y, 6'd0, coord_x}, 32'd0);
                    checkOutput("reissue_sof", 32'(coords_sof), 32'd1);
                end
                hsCount++;
            end
            tickCycle();
            cyc++;
        end
        checkOutput("basic_hs_count", 32'(hsCount), 32'd13);
        checkOutput("start_latency", 32'(firstCyc), 32'd2);
        checkOutput("throughput", 32'(lastIssueCyc - firstCyc), 32'd11);
        checkOutput("frame_done_count", 32'(doneCount), 32'd1);
        checkOutput("frame_done_latency", 32'(doneCyc - lastIssueCyc), 32'd2);
        checkOutput("restart_gap", 32'(reissueCyc - doneCyc), 32'd2);

        // Credit limit: no returns means only CREDITS issues
        resetDut();
        hsCount = 0;
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0);
            if (coords_valid) hsCount++;
            tickCycle();
        end
        checkOutput("limit_hs_count", 32'(hsCount), 32'd2);
        applyStimulus(1'b1, 1'b1, 1'b0);
        credit_return = 1'b1;
        #1;
        checkOutput("limit_valid", 32'(coords_valid), 32'd0);
        checkOutput("limit_inflight", 32'(inflight), 32'd2);
        tickCycle();
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("limit_resume_valid", 32'(coords_valid), 32'd1);
        checkOutput("limit_resume_x", 32'(coord_x), 32'd2);
        checkOutput("limit_resume_y", 32'(coord_y), 32'd0);
        checkOutput("limit_inflight_after", 32'(inflight), 32'd1);

        // Stall with offer (1,0) pending
        resetDut();
        cyc = 0;
        applyStimulus(1'b1, 1'b1, 1'b0);
        while (!coords_valid && cyc < 10) begin
            tickCycle();
            applyStimulus(1'b1, 1'b1, 1'b0);
            cyc++;
        end
        checkOutput("stall_first_offer", 32'(coords_valid), 32'd1);
        tickCycle();
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, 1'b0);
            checkOutput("stall_hold_x", 32'(coord_x), 32'd1);
            checkOutput("stall_hold_valid", 32'(coords_valid), 32'd1);
            tickCycle();
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("stall_release_x", 32'(coord_x), 32'd1);
        tickCycle();
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("stall_next_x", 32'(coord_x), 32'd2);
        checkOutput("stall_inflight", 32'(inflight), 32'd2);

        // Config snapshot across a frame boundary
        light_x_in = 32'h0093_EA1C;
        resetDut();
        cyc = 0;
        applyStimulus(1'b1, 1'b1, 1'b1);
        while (!coords_valid && cyc < 10) begin
            tickCycle();
            applyStimulus(1'b1, 1'b1, 1'b1);
            cyc++;
        end
        checkOutput("snap_first", light_x, 32'h0093_EA1C);
        checkOutput("snap_light_y", light_y, 32'h0000_1111);
        tickCycle();
        light_x_in = 32'h0100_0000;
        cyc = 0;
        applyStimulus(1'b1, 1'b1, 1'b1);
        while (!frame_done && cyc < 50) begin
            tickCycle();
            applyStimulus(1'b1, 1'b1, 1'b1);
            cyc++;
        end
        checkOutput("snap_at_done", light_x, 32'h0093_EA1C);
        tickCycle();
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("snap_in_latch", light_x, 32'h0093_EA1C);
        tickCycle();
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("snap_next_frame", light_x, 32'h0100_0000);

        // Stop mid-frame, then a bogus credit
        resetDut();
        hsCount = 0; doneCount = 0; cyc = 0;
        while (cyc < 100) begin
            applyStimulus(hsCount < 5, 1'b1, 1'b1);
            if (coords_valid) hsCount++;
            if (frame_done) doneCount++;
            if (!busy && hsCount > 0) break;
            tickCycle();
            cyc++;
        end
        checkOutput("stop_hs_count", 32'(hsCount), 32'd12);
        checkOutput("stop_done_count", 32'(doneCount), 32'd1);
        checkOutput("stop_busy", 32'(busy), 32'd0);
        tickCycle();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("stop_stays_idle", 32'(busy), 32'd0);
        checkOutput("err_before", 32'(credit_err), 32'd0);
        credit_return = 1'b1;
        tickCycle();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("err_set", 32'(credit_err), 32'd1);
        checkOutput("err_inflight", 32'(inflight), 32'd0);
        tickCycle();
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("err_sticky", 32'(credit_err), 32'd1);

        // Asynchronous reset mid-frame at (2,1) with two in flight
        light_x_in = 32'h0093_EA1C;
        resetDut();
        cyc = 0;
        applyStimulus(1'b1, 1'b1, 1'b1);
        while (!(coords_valid && coord_x == 10'd1 && coord_y == 9'd1) && cyc < 50) begin
            tickCycle();
            applyStimulus(1'b1, 1'b1, 1'b1);
            cyc++;
        end
        applyStimulus(1'b1, 1'b1, 1'b0);
        tickCycle();
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("pre_rst_inflight", 32'(inflight), 32'd2);
        checkOutput("pre_rst_xy", {coord_y, 6'd0, coord_x}, {9'd1, 6'd0, 10'd2, 7'd0} >> 7);
        checkOutput("pre_rst_light", light_x, 32'h0093_EA1C);
        periph_resetn = 1'b0;
        #1;
        checkOutput("arst_coord_x", 32'(coord_x), 32'd0);
        checkOutput("arst_coord_y", 32'(coord_y), 32'd0);
        checkOutput("arst_inflight", 32'(inflight), 32'd0);
        checkOutput("arst_light_x", light_x, 32'd0);
        checkOutput("arst_flags", {28'd0, coords_valid, coords_sof, coords_eol, busy}, 32'd0);
        @(negedge out_stream_aclk);
        periph_resetn = 1'b1;
        lastHs = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0);
        tickCycle();
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("restart_latch_busy", 32'(busy), 32'd1);
        tickCycle();
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("restart_valid", 32'(coords_valid), 32'd1);
        checkOutput("restart_xy", {coord_y, 6'd0, coord_x}, 32'd0);
        checkOutput("restart_sof", 32'(coords_sof), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule

// File: doc/ray_issue_scheduler.md
# ray_issue_scheduler

Frame-level sequencer for the ray-marching pixel datapath, running in the `out_stream_aclk` domain between the AXI-Lite register file and the ray unit. It emits screen coordinates in raster order under credit-based flow control, so the number of pixels in flight never exceeds the downstream result FIFO depth. At each frame boundary it snapshots the light-position registers into shadow copies, so every pixel of a frame is shaded with one consistent configuration.

## Interface
Parameters:
- `SCREEN_WIDTH`, default 640: pixels per line.
- `SCREEN_HEIGHT`, default 480: lines per frame.
- `CREDITS`, default 16: downstream result FIFO depth, which is the maximum number of pixels in flight.

Ports:
- `out_stream_aclk`  in  1  the only clock.
- `periph_resetn`  in  1  reset, asynchronous, active-low.
- `enable`  in  1  high means run frames back-to-back; low means stop after the current frame.
- `light_x_in`, `light_y_in`, `light_z_in`  in  32 each  live light position from the register file.
- `light_x`, `light_y`, `light_z`  out  32 each  shadow light position, stable for a whole frame.
- `coord_x`  out  10  screen x of the issued pixel.
- `coord_y`  out  9  screen y of the issued pixel.
- `coords_valid`  out  1  coordinate offer to the ray unit.
- `coords_ready`  in  1  ray unit accepts the offer.
- `coords_sof`  out  1  high with the (0,0) offer.
- `coords_eol`  out  1  high when `coord_x == SCREEN_WIDTH-1`.
- `credit_return`  in  1  one-cycle pulse per pixel popped from the downstream FIFO.
- `inflight`  out  `$clog2(CREDITS+1)`  pixels issued and not yet returned.
- `busy`  out  1  state is not IDLE.
- `frame_done`  out  1  one-cycle pulse when a frame has fully drained.
- `credit_err`  out  1  sticky flag, set by a `credit_return` pulse while `inflight == 0`.

## Operation
- An issue handshake is `coords_valid && coords_ready`.
- IDLE: `coords_valid` is 0. If `enable` is high, go to LATCH.
- LATCH, exactly 1 cycle:
  - Copy `light_*_in` into `light_*`.
  - Set `coord_x` and `coord_y` to 0.
  - Go to ISSUE.
- ISSUE:
  - `coords_valid = (inflight < CREDITS)`.
  - On each handshake, advance raster order: increment x; at `SCREEN_WIDTH-1`, x wraps to 0 and y increments.
  - A handshake on (`SCREEN_WIDTH-1`, `SCREEN_HEIGHT-1`) goes to DRAIN, and the coordinates return to (0,0).
- DRAIN:
  - `coords_valid` is 0.
  - When `inflight == 0`, pulse `frame_done`.
  - In that same cycle, go to LATCH if `enable` is high, else to IDLE.
- Offer stability: while `coords_valid` is high and `coords_ready` is low, `coord_x`, `coord_y`, `coords_sof` and `coords_eol` are held. Once `coords_valid` is asserted it stays high until the handshake, because `inflight` can only fall while stalled.
- `inflight` update:
  - Increment on a handshake.
  - Decrement on `credit_return`.
  - Both in the same cycle: unchanged.
  - `credit_return` while `inflight == 0`: `inflight` stays 0 and `credit_err` is set.
  - `credit_err` clears only on reset.
- `enable` falling mid-frame does not abort. The frame finishes, drains, then the block goes to IDLE.
- `light_*_in` changes outside LATCH have no effect on `light_*`.
- `coords_sof` and `coords_eol` are combinational from `coord_x`/`coord_y`, qualified by `coords_valid`.

## Timing
- Reset values (asynchronous, while `periph_resetn` is low): state IDLE; `coord_x`, `coord_y`, `inflight`, `light_*` all 0; `coords_valid`, `coords_sof`, `coords_eol`, `busy`, `frame_done`, `credit_err` all 0.
- Reset asserted mid-frame: everything returns to reset values immediately. Credits already in flight are forgotten, so downstream must be reset together with this block.
- Start latency: `enable` is sampled high in IDLE at edge N. LATCH is active in cycle N+1. `coords_valid` is first high in cycle N+2, provided `CREDITS >= 1`.
- Throughput: with `coords_ready` held at 1 and a credit returned every cycle, one pixel issues per cycle.
- `frame_done` latency: `frame_done` is high in the first cycle where state is DRAIN and `inflight == 0`. That is the cycle after the final credit return, or the cycle after the last issue if all credits are already back.
- Frame-to-frame gap: after `frame_done`, there is 1 LATCH cycle, then ISSUE.
- `inflight` is registered. A credit returned in cycle N allows an issue in cycle N+1, not in cycle N.

## Test plan
Simulation parameters: `SCREEN_WIDTH=4`, `SCREEN_HEIGHT=3`, `CREDITS=2`.
- Basic frame: `enable=1`, `coords_ready=1`, `credit_return` 1 cycle after each issue → 12 handshakes in order (0,0),(1,0)..(3,2). `coords_sof` only on (0,0). `coords_eol` on x=3. One `frame_done`, then (0,0) reissued 2 cycles later.
- Credit limit: `coords_ready=1`, no credit returns → exactly 2 handshakes, then `coords_valid` is 0 and `inflight=2`. One `credit_return` → `coords_valid` is high the next cycle with (2,0).
- Stall: `coords_ready=0` for 5 cycles while the offer (1,0) is pending → `coord_x=1` and `coords_valid=1` are held throughout. Release → (1,0) is accepted once, with no skip or duplicate.
- Config snapshot: `light_x_in=0x0093EA1C` at start; change it to `0x01000000` mid-frame → `light_x` stays `0x0093EA1C` until the next LATCH, then becomes `0x01000000`.
- Stop and error: drop `enable` mid-frame → the frame completes, `frame_done` pulses once, state goes to IDLE with `busy=0`. A `credit_return` pulse at `inflight=0` → `credit_err=1`, `inflight` stays 0.
- Reset mid-frame: assert `periph_resetn=0` with `inflight=2` at (2,1) → all outputs go to 0 asynchronously. Release with `enable=1` → the frame restarts at (0,0).
